// File: rtl/serv_pkg.sv
// Shared definitions for the SERV bus-facing blocks: fetch state encoding and
// the default watchdog limit also used by the data-bus interface.
package serv_pkg;

  typedef enum logic {
    FETCH_IDLE = 1'b0,
    FETCH_BUSY = 1'b1
  } fetch_state_e;

  localparam int DEFAULT_TIMEOUT   = 255;
  localparam int DEFAULT_TIMEOUT_W = 8;

endpackage

// File: rtl/serv_bus_timer.sv
// Saturating bus watchdog: cleared when a transfer starts, counts idle-ack
// cycles, and flags expiry on the last permitted cycle.
module serv_bus_timer
  import serv_pkg::*;
#(
  parameter int TIMEOUT   = DEFAULT_TIMEOUT,
  parameter int TIMEOUT_W = DEFAULT_TIMEOUT_W
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_inc,
  output logic o_expired
);

  logic [TIMEOUT_W-1:0] count_q;
  logic [TIMEOUT_W-1:0] count_d;

  // Clear wins over increment; the count sticks at all-ones instead of wrapping.
  always_comb begin
    count_d = count_q;
    if (i_clear) begin
      count_d = '0;
    end else if (i_inc && (count_q != '1)) begin
      count_d = count_q + TIMEOUT_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_expired = (count_q == TIMEOUT_W'(TIMEOUT - 1));

endmodule

// File: rtl/serv_fetch.sv
// Instruction-fetch stage: one Wishbone-classic read per request, with
// misalignment rejection, flush handling and an optional bus-timeout watchdog.
module serv_fetch
  import serv_pkg::*;
#(
  parameter int WITH_TIMEOUT = 1,
  parameter int TIMEOUT      = DEFAULT_TIMEOUT,
  parameter int TIMEOUT_W    = DEFAULT_TIMEOUT_W
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_fetch_req,
  input  logic [31:0] i_pc,
  input  logic        i_flush,
  output logic        o_busy,
  output logic [31:0] o_ibus_adr,
  output logic        o_ibus_cyc,
  input  logic [31:0] i_ibus_rdt,
  input  logic        i_ibus_ack,
  output logic        o_wb_en,
  output logic [31:0] o_wb_rdt,
  output logic        o_misalign,
  output logic        o_fetch_err
);

  fetch_state_e state_q, state_d;
  logic [31:0]  adr_q, adr_d;
  logic         cyc_q, cyc_d;
  logic         wb_en_q, wb_en_d;
  logic [31:0]  wb_rdt_q, wb_rdt_d;
  logic         misalign_q, misalign_d;
  logic         fetch_err_q, fetch_err_d;
  logic         tmr_clear;
  logic         tmr_inc;
  logic         tmr_expired;

  generate
    if (WITH_TIMEOUT != 0) begin : g_timer
      serv_bus_timer #(
        .TIMEOUT   (TIMEOUT),
        .TIMEOUT_W (TIMEOUT_W)
      ) u_timer (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clear   (tmr_clear),
        .i_inc     (tmr_inc),
        .o_expired (tmr_expired)
      );
    end else begin : g_no_timer
      assign tmr_expired = 1'b0;
    end
  endgenerate

  // Single-cycle strobes default low; flush beats ack, ack beats timeout.
  always_comb begin
    state_d     = state_q;
    adr_d       = adr_q;
    cyc_d       = cyc_q;
    wb_rdt_d    = wb_rdt_q;
    wb_en_d     = 1'b0;
    misalign_d  = 1'b0;
    fetch_err_d = 1'b0;
    tmr_clear   = 1'b0;
    tmr_inc     = 1'b0;
    case (state_q)
      FETCH_IDLE: begin
        if (i_fetch_req && !i_flush) begin
          if (i_pc[1:0] == 2'b00) begin
            adr_d     = {i_pc[31:2], 2'b00};
            cyc_d     = 1'b1;
            tmr_clear = 1'b1;
            state_d   = FETCH_BUSY;
          end else begin
            misalign_d = 1'b1;
          end
        end
      end
      FETCH_BUSY: begin
        if (i_flush) begin
          cyc_d   = 1'b0;
          state_d = FETCH_IDLE;
        end else if (i_ibus_ack) begin
          wb_rdt_d = i_ibus_rdt;
          wb_en_d  = 1'b1;
          cyc_d    = 1'b0;
          state_d  = FETCH_IDLE;
        end else if (tmr_expired) begin
          fetch_err_d = 1'b1;
          cyc_d       = 1'b0;
          state_d     = FETCH_IDLE;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      default: begin
        cyc_d   = 1'b0;
        state_d = FETCH_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= FETCH_IDLE;
      adr_q       <= '0;
      cyc_q       <= 1'b0;
      wb_en_q     <= 1'b0;
      wb_rdt_q    <= '0;
      misalign_q  <= 1'b0;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      adr_q       <= adr_d;
      cyc_q       <= cyc_d;
      wb_en_q     <= wb_en_d;
      wb_rdt_q    <= wb_rdt_d;
      misalign_q  <= misalign_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  assign o_busy      = (state_q == FETCH_BUSY);
  assign o_ibus_adr  = adr_q;
  assign o_ibus_cyc  = cyc_q;
  assign o_wb_en     = wb_en_q;
  assign o_wb_rdt    = wb_rdt_q;
  assign o_misalign  = misalign_q;
  assign o_fetch_err = fetch_err_q;

endmodule

// File: tb/tb_serv_fetch.sv
// Directed bench for serv_fetch with a short watchdog (TIMEOUT=4); inputs change
// 1 ns after each rising edge and outputs are checked there too.
module tb_serv_fetch;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_fetch_req;
  logic [31:0] i_pc;
  logic        i_flush;
  logic        o_busy;
  logic [31:0] o_ibus_adr;
  logic        o_ibus_cyc;
  logic [31:0] i_ibus_rdt;
  logic        i_ibus_ack;
  logic        o_wb_en;
  logic [31:0] o_wb_rdt;
  logic        o_misalign;
  logic        o_fetch_err;

  int total;
  int bad;

  serv_fetch #(
    .WITH_TIMEOUT (1),
    .TIMEOUT      (4),
    .TIMEOUT_W    (8)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_fetch_req (i_fetch_req),
    .i_pc        (i_pc),
    .i_flush     (i_flush),
    .o_busy      (o_busy),
    .o_ibus_adr  (o_ibus_adr),
    .o_ibus_cyc  (o_ibus_cyc),
    .i_ibus_rdt  (i_ibus_rdt),
    .i_ibus_ack  (i_ibus_ack),
    .o_wb_en     (o_wb_en),
    .o_wb_rdt    (o_wb_rdt),
    .o_misalign  (o_misalign),
    .o_fetch_err (o_fetch_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, want);
    end
  endtask

  task automatic check_idle_strobes(input string tag);
    check_output({tag, ".cyc"}, {31'd0, o_ibus_cyc}, 32'd0);
    check_output({tag, ".busy"}, {31'd0, o_busy}, 32'd0);
    check_output({tag, ".wb_en"}, {31'd0, o_wb_en}, 32'd0);
    check_output({tag, ".misalign"}, {31'd0, o_misalign}, 32'd0);
    check_output({tag, ".fetch_err"}, {31'd0, o_fetch_err}, 32'd0);
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    i_rst_n     = 1'b0;
    i_fetch_req = 1'b0;
    i_pc        = '0;
    i_flush     = 1'b0;
    i_ibus_rdt  = '0;
    i_ibus_ack  = 1'b0;

    // Reset values
    #3;
    check_idle_strobes("rst");
    check_output("rst.adr", o_ibus_adr, 32'h0);
    check_output("rst.rdt", o_wb_rdt, 32'h0);
    tick();
    tick();
    i_rst_n = 1'b1;
    tick();
    check_idle_strobes("rst_rel");

    // 1: normal fetch, ack on second BUSY cycle
    $display("[TB] fetch with ack on second busy cycle");
    i_fetch_req = 1'b1;
    i_pc        = 32'h0000_0104;
    tick();
    i_fetch_req = 1'b0;
    check_output("t1.cyc1", {31'd0, o_ibus_cyc}, 32'd1);
    check_output("t1.busy1", {31'd0, o_busy}, 32'd1);
    check_output("t1.adr1", o_ibus_adr, 32'h0000_0104);
    check_output("t1.wb_en1", {31'd0, o_wb_en}, 32'd0);
    tick();
    check_output("t1.cyc2", {31'd0, o_ibus_cyc}, 32'd1);
    check_output("t1.adr2", o_ibus_adr, 32'h0000_0104);
    i_ibus_ack = 1'b1;
    i_ibus_rdt = 32'h0050_0093;
    tick();
    i_ibus_ack = 1'b0;
    i_ibus_rdt = 32'h0;
    check_output("t1.wb_en", {31'd0, o_wb_en}, 32'd1);
    check_output("t1.rdt", o_wb_rdt, 32'h0050_0093);
    check_output("t1.cyc_done", {31'd0, o_ibus_cyc}, 32'd0);
    check_output("t1.busy_done", {31'd0, o_busy}, 32'd0);
    tick();
    check_output("t1.wb_en_off", {31'd0, o_wb_en}, 32'd0);
    check_output("t1.rdt_hold", o_wb_rdt, 32'h0050_0093);

    // 2: misaligned request
    $display("[TB] misaligned request");
    i_fetch_req = 1'b1;
    i_pc        = 32'h0000_0106;
    tick();
    i_fetch_req = 1'b0;
    check_output("t2.misalign", {31'd0, o_misalign}, 32'd1);
    check_output("t2.cyc", {31'd0, o_ibus_cyc}, 32'd0);
    check_output("t2.busy", {31'd0, o_busy}, 32'd0);
    tick();
    check_idle_strobes("t2.after");

    // 3a: watchdog expiry after exactly four BUSY cycles
    $display("[TB] bus timeout");
    i_fetch_req = 1'b1;
    i_pc        = 32'h0000_0200;
    tick();
    i_fetch_req = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      check_output($sformatf("t3a.cyc%0d", k), {31'd0, o_ibus_cyc}, 32'd1);
      check_output($sformatf("t3a.err%0d", k), {31'd0, o_fetch_err}, 32'd0);
      tick();
    end
    check_output("t3a.err", {31'd0, o_fetch_err}, 32'd1);
    check_output("t3a.cyc_off", {31'd0, o_ibus_cyc}, 32'd0);
    check_output("t3a.busy_off", {31'd0, o_busy}, 32'd0);
    check_output("t3a.wb_en", {31'd0, o_wb_en}, 32'd0);
    check_output("t3a.rdt_hold", o_wb_rdt, 32'h0050_0093);
    tick();
    check_idle_strobes("t3a.after");

    // 3b: ack in the timeout cycle completes normally
    $display("[TB] ack in timeout cycle");
    i_fetch_req = 1'b1;
    i_pc        = 32'h0000_0204;
    tick();
    i_fetch_req = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      check_output($sformatf("t3b.cyc%0d", k), {31'd0, o_ibus_cyc}, 32'd1);
      tick();
    end
    check_output("t3b.cyc4", {31'd0, o_ibus_cyc}, 32'd1);
    i_ibus_ack = 1'b1;
    i_ibus_rdt = 32'h1111_1111;
    tick();
    i_ibus_ack = 1'b0;
    check_output("t3b.wb_en", {31'd0, o_wb_en}, 32'd1);
    check_output("t3b.err", {31'd0, o_fetch_err}, 32'd0);
    check_output("t3b.rdt", o_wb_rdt, 32'h1111_1111);
    tick();
    check_idle_strobes("t3b.after");

    // 4: flush with same-cycle ack discards the data
    $display("[TB] flush with ack");
    i_fetch_req = 1'b1;
    i_pc        = 32'h0000_0300;
    tick();
    i_fetch_req = 1'b0;
    check_output("t4.cyc", {31'd0, o_ibus_cyc}, 32'd1);
    i_flush    = 1'b1;
    i_ibus_ack = 1'b1;
    i_ibus_rdt = 32'hDEAD_BEEF;
    tick();
    i_flush    = 1'b0;
    i_ibus_ack = 1'b0;
    check_idle_strobes("t4.flush");
    check_output("t4.rdt_hold", o_wb_rdt, 32'h1111_1111);
    // flush in IDLE suppresses both acceptance and misalign
    i_flush     = 1'b1;
    i_fetch_req = 1'b1;
    i_pc        = 32'h0000_0302;
    tick();
    check_idle_strobes("t4.idle_mis");
    i_pc = 32'h0000_0304;
    tick();
    i_flush     = 1'b0;
    i_fetch_req = 1'b0;
    check_idle_strobes("t4.idle_ok");

    // 5: asynchronous reset during BUSY
    $display("[TB] reset mid-busy");
    i_fetch_req = 1'b1;
    i_pc        = 32'h0000_0400;
    tick();
    i_fetch_req = 1'b0;
    check_output("t5.cyc", {31'd0, o_ibus_cyc}, 32'd1);
    #2;
    i_rst_n = 1'b0;
    #1;
    check_output("t5.cyc_async", {31'd0, o_ibus_cyc}, 32'd0);
    check_output("t5.busy_async", {31'd0, o_busy}, 32'd0);
    tick();
    i_rst_n = 1'b1;
    tick();
    check_idle_strobes("t5.rel");
    check_output("t5.adr", o_ibus_adr, 32'h0);
    check_output("t5.rdt", o_wb_rdt, 32'h0);
    i_fetch_req = 1'b1;
    i_pc        = 32'h0000_0500;
    tick();
    i_fetch_req = 1'b0;
    check_output("t5.cyc_new", {31'd0, o_ibus_cyc}, 32'd1);
    check_output("t5.adr_new", o_ibus_adr, 32'h0000_0500);

    // 6: back-to-back request in the wb_en cycle; extra req while BUSY ignored
    $display("[TB] back-to-back fetch");
    i_ibus_ack = 1'b1;
    i_ibus_rdt = 32'hAAAA_5555;
    tick();
    i_ibus_ack = 1'b0;
    check_output("t6.wb_en1", {31'd0, o_wb_en}, 32'd1);
    check_output("t6.rdt1", o_wb_rdt, 32'hAAAA_5555);
    i_fetch_req = 1'b1;
    i_pc        = 32'h0000_0108;
    tick();
    i_fetch_req = 1'b0;
    check_output("t6.cyc", {31'd0, o_ibus_cyc}, 32'd1);
    check_output("t6.adr", o_ibus_adr, 32'h0000_0108);
    check_output("t6.wb_en_off", {31'd0, o_wb_en}, 32'd0);
    i_fetch_req = 1'b1;
    i_pc        = 32'h0000_010C;
    tick();
    i_fetch_req = 1'b0;
    check_output("t6.adr_stable", o_ibus_adr, 32'h0000_0108);
    check_output("t6.cyc2", {31'd0, o_ibus_cyc}, 32'd1);
    i_ibus_ack = 1'b1;
    i_ibus_rdt = 32'h1234_5678;
    tick();
    i_ibus_ack = 1'b0;
    check_output("t6.wb_en2", {31'd0, o_wb_en}, 32'd1);
    check_output("t6.rdt2", o_wb_rdt, 32'h1234_5678);
    tick();
    check_idle_strobes("t6.no_queue");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
